audio_fifo_packer: RTL

//  Upstream feeder for the HPS-visible fifo_1_in Avalon-MM FIFO. Accepts a 16-bit L/R sample stream,

---
 rtl/audio_fifo_pkg.sv | 22 ++
 rtl/audio_fifo_packer_if.sv | 47 ++++
 rtl/audio_fifo_packer_sync_fifo.sv | 54 +++++
 rtl/audio_fifo_packer.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/audio_fifo_pkg.sv
// Shared types and constants for the audio sample packer that feeds the HPS-visible FIFO.
package audio_fifo_pkg;

    localparam int SAMPLE_W = 16;
    localparam int WORD_W   = 2 * SAMPLE_W;

    localparam logic [2:0] FIFO_CSR_LEVEL = 3'd0;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITE     = 2'd1,
        POLL_REQ  = 2'd2,
        POLL_WAIT = 2'd3
    } state_t;

    // Free space left downstream; a fill at or beyond capacity means no credit.
    function automatic logic [31:0] credit_from_fill(input logic [31:0] fill,
                                                     input logic [31:0] depth);
        return (fill >= depth) ? 32'd0 : (depth - fill);
    endfunction

endpackage

// File: rtl/audio_fifo_packer_if.sv
// Sample stream, Avalon-MM write slave and FIFO CSR signals of the packer.
interface audio_fifo_packer_if;
    import audio_fifo_pkg::*;

    logic [SAMPLE_W-1:0] s_data;
    logic                s_chan;
    logic                s_valid;
    logic                s_ready;

    logic [WORD_W-1:0]   avm_writedata;
    logic                avm_write;
    logic                avm_address;
    logic                avm_waitrequest;

    logic [2:0]          csr_address;
    logic                csr_read;
    logic [31:0]         csr_readdata;

    modport master (
        input  s_data,
        input  s_chan,
        input  s_valid,
        output s_ready,
        output avm_writedata,
        output avm_write,
        output avm_address,
        input  avm_waitrequest,
        output csr_address,
        output csr_read,
        input  csr_readdata
    );

    modport slave (
        output s_data,
        output s_chan,
        output s_valid,
        input  s_ready,
        input  avm_writedata,
        input  avm_write,
        input  avm_address,
        output avm_waitrequest,
        input  csr_address,
        input  csr_read,
        output csr_readdata
    );

endinterface

// File: rtl/audio_fifo_packer_sync_fifo.sv
// First-word-fall-through synchronous FIFO holding packed words until the downstream write.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_C);
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a full buffer can still take a push.
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/audio_fifo_packer.sv
// Packs L/R sample pairs into 32-bit words and writes them to a downstream FIFO
// under credit-based flow control refreshed by polling the FIFO fill level.
//
//  state     | meaning
//  ----------+------------------------------------------------------------
//  IDLE      | wait for buffered word with credit, or a due fill-level poll
//  WRITE     | avm_write held with buffer head until waitrequest drops
//  POLL_REQ  | one-cycle csr_read of the fill-level register
//  POLL_WAIT | readdata valid: reload credit and poll timer
module audio_fifo_packer
    import audio_fifo_pkg::*;
#(
    parameter int BUF_DEPTH   = 4,
    parameter int FIFO_DEPTH  = 256,
    parameter int POLL_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    audio_fifo_packer_if.master bus,
    output logic                pair_err,
    output logic [15:0]         drop_cnt
);

    localparam int CREDIT_W = $clog2(FIFO_DEPTH + 1);
    localparam int TIMER_W  = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(POLL_CYCLES - 1);

    state_t                state;
    state_t                state_nxt;
    logic [CREDIT_W-1:0]   credit;
    logic [TIMER_W-1:0]    timer;

    logic [SAMPLE_W-1:0]   half_data;
    logic                  half_full;

    logic                  s_ready;
    logic                  s_accept;
    logic                  drop_l;
    logic                  drop_r;

    logic                  buf_push;
    logic                  buf_pop;
    logic                  buf_full;
    logic                  buf_empty;
    logic [WORD_W-1:0]     buf_wdata;
    logic [WORD_W-1:0]     buf_head;

    logic                  avm_write;
    logic                  csr_read;
    logic                  wr_accept;
    logic                  poll_due;

    sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk   (clk),
        .reset (reset),
        .push  (buf_push),
        .wdata (buf_wdata),
        .pop   (buf_pop),
        .rdata (buf_head),
        .full  (buf_full),
        .empty (buf_empty)
    );

    assign s_ready     = enable & ~buf_full;
    assign bus.s_ready = s_ready;
    assign s_accept    = bus.s_valid & s_ready;

    // A right sample completes the pair and lands in the buffer in the accept cycle.
    assign buf_push  = s_accept & bus.s_chan & half_full;
    assign buf_wdata = {half_data, bus.s_data};
    assign drop_l    = s_accept & ~bus.s_chan & half_full;
    assign drop_r    = s_accept & bus.s_chan & ~half_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            half_data <= '0;
            half_full <= 1'b0;
            pair_err  <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            if (s_accept) begin
                if (!bus.s_chan) begin
                    half_data <= bus.s_data;
                    half_full <= 1'b1;
                end else begin
                    half_full <= 1'b0;
                end
            end
            if (drop_l | drop_r) begin
                pair_err <= 1'b1;
                if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

    assign wr_accept = (state == WRITE) & ~bus.avm_waitrequest;
    assign poll_due  = ((credit == '0) & ~buf_empty) | (timer == '0);

    // No write is in flight during a poll, so the returned fill is exact.
    always_ff @(posedge clk) begin
        if (reset) begin
            credit <= '0;
        end else if (state == POLL_WAIT) begin
            credit <= CREDIT_W'(credit_from_fill(bus.csr_readdata, 32'(FIFO_DEPTH)));
        end else if (wr_accept) begin
            credit <= credit - 1'b1;
        end
    end

    // Down-counter to the next forced poll; holds at terminal count until the poll happens.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer <= TIMER_LOAD;
        end else if (state == POLL_WAIT) begin
            timer <= TIMER_LOAD;
        end else if (((state == IDLE) | (state == WRITE)) & (timer != '0)) begin
            timer <= timer - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        avm_write = 1'b0;
        csr_read  = 1'b0;
        buf_pop   = 1'b0;
        case (state)
            IDLE: begin
                if (poll_due) begin
                    state_nxt = POLL_REQ;
                end else if (enable & ~buf_empty & (credit != '0)) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                // Once started, a write is never withdrawn, even if enable drops.
                avm_write = 1'b1;
                if (!bus.avm_waitrequest) begin
                    buf_pop   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            POLL_REQ: begin
                csr_read  = 1'b1;
                state_nxt = POLL_WAIT;
            end
            POLL_WAIT: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.avm_write     = avm_write;
    assign bus.avm_writedata = avm_write ? buf_head : '0;
    assign bus.avm_address   = 1'b0;
    assign bus.csr_read      = csr_read;
    assign bus.csr_address   = FIFO_CSR_LEVEL;

endmodule
